memory_storer: RTL and testbench
================================

Name: memory_storer

Overview:
- Store-side memory interface unit, the write counterpart of the load result aligner.
- Accepts one store per handshake from the execute/memory stage: byte address, rs2 data and funct3 (sb/sh/sw).
- Drives a word-addressed data memory write port with byte strobes, using a req/ack handshake.
- Misaligned stores that cross a word boundary are split into two word writes, unless disabled by parameter.

Parameters:
- ALLOW_MISALIGNED, 1: 1 = split word-crossing stores into two writes; 0 = report a store error and issue no write.
- TIMEOUT_CYCLES, 0: maximum cycles mem_req may wait for mem_ack before the store aborts with an error; 0 = no timeout.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- store_valid  input  1  store request present
- store_ready  output  1  unit can accept a request; high only in IDLE
- store_address  input  32  byte address of the store
- store_data  input  32  rs2 value; only the low 8/16/32 bits are used per funct3
- funct3  input  3  000 sb, 001 sh, 010 sw; any other value is illegal
- mem_req  output  1  write request to memory
- mem_addr  output  32  word-aligned write address, bits [1:0] always 00
- mem_wdata  output  32  lane-aligned write data
- mem_wstrb  output  4  byte enables; bit i enables mem_wdata[8i+7:8i]
- mem_ack  input  1  memory accepted the current write
- store_done  output  1  one-cycle pulse: store fully written
- store_error  output  1  one-cycle pulse: illegal funct3, disallowed misalignment, or timeout

Behaviour:
- Reset (asynchronous, immediate):
  - Outputs: mem_req=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, store_done=0, store_error=0.
  - State goes to IDLE, so store_ready=1.
  - Reset during WR0 or WR1 abandons the store: mem_req drops at once and no done or error pulse follows.
- States: IDLE, WR0, WR1, ERR.
- Decode at accept (store_valid & store_ready):
  - Latch store_address, store_data and funct3.
  - off = store_address[1:0].
  - mask = 0001 for sb, 0011 for sh, 1111 for sw.
  - size = 1, 2 or 4.
  - spill = (off + size > 4).
- IDLE transitions on accept:
  - Illegal funct3 -> ERR.
  - spill with ALLOW_MISALIGNED=0 -> ERR.
  - Otherwise -> WR0.
- WR0 outputs (all registered, stable while waiting):
  - mem_req=1.
  - mem_addr = {addr[31:2],2'b00}.
  - mem_wdata = store_data << (8*off).
  - mem_wstrb = (mask << off)[3:0].
- WR0 on mem_ack:
  - If spill -> WR1.
  - Else -> IDLE, with store_done=1 for one cycle and mem_req=0 in the same cycle.
- WR1 outputs:
  - mem_req=1.
  - mem_addr = {addr[31:2],2'b00} + 4, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000).
  - mem_wdata = store_data >> (8*(4-off)).
  - mem_wstrb = mask >> (4-off).
- WR1 on mem_ack -> IDLE, store_done pulse.
- ERR: lasts exactly one cycle with store_error=1 and no mem_req, then -> IDLE.
- Back-to-back: store_ready returns high in the same cycle as the store_done pulse, so the next accept can happen in that cycle.
- Minimum latency for an aligned store with mem_ack held high: accept at cycle 0, mem_req at cycle 1, store_done at cycle 2.
- Handshake rules:
  - mem_req, once asserted, stays high with stable addr/wdata/wstrb until mem_ack.
  - mem_ack while mem_req=0 is ignored.
  - store_* inputs are ignored outside IDLE.
- Timeout (TIMEOUT_CYCLES > 0):
  - A counter clears on entry to WR0 and on entry to WR1.
  - It increments each cycle mem_req=1 and mem_ack=0.
  - When it reaches TIMEOUT_CYCLES without ack -> ERR (mem_req drops).
  - If the timeout hits in WR1, the first write already done is not rolled back.
- mem_ack and timeout in the same cycle: the ack wins.

Test Plan:
- Reset asserted mid-WR0 (sw to 0x100, mem_ack=0) -> mem_req=0 at once, store_ready=1, no store_done or store_error ever.
- sw, addr 0x0000_1000, data 0x1122_3344, ack=1 -> one write: addr 0x1000, wdata 0x11223344, wstrb 1111; store_done at cycle 2.
- sb, addr 0x1003, data 0xFFFF_FFAB -> addr 0x1000, wdata 0xAB000000, wstrb 1000, single write.
- sh, addr 0x1003, data 0xBEEF:
  - First write: addr 0x1000, wdata 0xEF000000, wstrb 1000.
  - Second write: addr 0x1004, wdata 0x000000BE, wstrb 0001.
  - store_done after the second ack.
- sw, addr 0xFFFF_FFFE, data 0x1122_3344, ack delayed 3 cycles per write:
  - Writes: 0xFFFFFFFC/0x33440000/1100, then 0x00000000/0x00001122/0011.
  - Signals stay stable while waiting.
- funct3=011 -> store_error for one cycle, no mem_req. ALLOW_MISALIGNED=0 with sh at 0x3 -> store_error. TIMEOUT_CYCLES=4 with no ack -> store_error 4 cycles after the first mem_req.

Source files
------------

// File: rtl/memory_storer.sv
// Store-side memory interface: turns one sb/sh/sw request into one or two
// word-aligned strobed writes over a req/ack port, with optional ack timeout.
module memory_storer #(
   parameter bit          ALLOW_MISALIGNED = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES   = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        store_valid,
   output logic        store_ready,
   input  logic [31:0] store_address,
   input  logic [31:0] store_data,
   input  logic [2:0]  funct3,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ack,
   output logic        store_done,
   output logic        store_error
);

   typedef enum logic [1:0] {IDLE, WR0, WR1, ERR} state_t;

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_t           state_q, state_d;
   logic [29:0]      base_q, base_d;
   logic [31:0]      data_q, data_d;
   logic [1:0]       off_q, off_d;
   logic [3:0]       mask_q, mask_d;
   logic             spill_q, spill_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic        accept, legal, dec_spill, waiting, to_hit;
   logic [3:0]  dec_mask;
   logic [2:0]  dec_size;
   logic [7:0]  strb_wide;
   logic [5:0]  hi_shift;

   assign accept = store_valid && (state_q == IDLE);

   always_comb begin
      legal    = 1'b1;
      dec_mask = 4'b0000;
      dec_size = 3'd0;
      case (funct3)
         3'b000:  begin dec_mask = 4'b0001; dec_size = 3'd1; end
         3'b001:  begin dec_mask = 4'b0011; dec_size = 3'd2; end
         3'b010:  begin dec_mask = 4'b1111; dec_size = 3'd4; end
         default: legal = 1'b0;
      endcase
      dec_spill = ({2'b00, store_address[1:0]} + {1'b0, dec_size}) > 4'd4;
   end

   // Unused upper lanes are zeroed at capture so the spill shift never leaks them.
   always_comb begin
      base_d  = base_q;
      data_d  = data_q;
      off_d   = off_q;
      mask_d  = mask_q;
      spill_d = spill_q;
      if (accept) begin
         base_d  = store_address[31:2];
         data_d  = store_data & {{8{dec_mask[3]}}, {8{dec_mask[2]}},
                                 {8{dec_mask[1]}}, {8{dec_mask[0]}}};
         off_d   = store_address[1:0];
         mask_d  = dec_mask;
         spill_d = dec_spill;
      end
   end

   assign waiting = ((state_q == WR0) || (state_q == WR1)) && !mem_ack;
   assign to_hit  = (TIMEOUT_CYCLES != 0) && waiting && (cnt_q == TO_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == IDLE) || ((state_q == WR0) && mem_ack))
         cnt_d = '0;
      else if (waiting)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (accept) begin
            if (!legal || (dec_spill && !ALLOW_MISALIGNED)) state_d = ERR;
            else                                            state_d = WR0;
         end
         WR0: begin
            if (mem_ack) begin
               if (spill_q) state_d = WR1;
               else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else if (to_hit) state_d = ERR;
         end
         WR1: begin
            if (mem_ack) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (to_hit) state_d = ERR;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      base_q  <= base_d;
      data_q  <= data_d;
      off_q   <= off_d;
      mask_q  <= mask_d;
      spill_q <= spill_d;
   end

   // Write-port fields are a pure function of state and captured request, so
   // they hold steady for as long as a write waits on its ack.
   assign strb_wide = {4'b0000, mask_q} << off_q;
   assign hi_shift  = 6'd32 - {1'b0, off_q, 3'b000};

   always_comb begin
      store_ready = (state_q == IDLE);
      store_error = (state_q == ERR);
      store_done  = done_q;
      mem_req     = 1'b0;
      mem_addr    = 32'h0;
      mem_wdata   = 32'h0;
      mem_wstrb   = 4'b0000;
      case (state_q)
         WR0: begin
            mem_req   = 1'b1;
            mem_addr  = {base_q, 2'b00};
            mem_wdata = data_q << {off_q, 3'b000};
            mem_wstrb = strb_wide[3:0];
         end
         WR1: begin
            mem_req   = 1'b1;
            mem_addr  = {base_q + 30'd1, 2'b00};
            mem_wdata = data_q >> hi_shift;
            mem_wstrb = mask_q >> (3'd4 - {1'b0, off_q});
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_memory_storer.sv
// Directed bench for memory_storer: default, no-misalign and timeout variants.
module tb_memory_storer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  store_valid = 3'b000;
   logic [31:0] store_address = 32'h0;
   logic [31:0] store_data = 32'h0;
   logic [2:0]  funct3 = 3'b000;
   logic [2:0]  mem_ack = 3'b000;

   logic [2:0]  ready, req, done, err;
   logic [31:0] addr_o  [3];
   logic [31:0] wdata_o [3];
   logic [3:0]  wstrb_o [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   memory_storer dut (
      .clk(clk), .reset(reset), .store_valid(store_valid[0]), .store_ready(ready[0]),
      .store_address(store_address), .store_data(store_data), .funct3(funct3),
      .mem_req(req[0]), .mem_addr(addr_o[0]), .mem_wdata(wdata_o[0]), .mem_wstrb(wstrb_o[0]),
      .mem_ack(mem_ack[0]), .store_done(done[0]), .store_error(err[0]));

   memory_storer #(.ALLOW_MISALIGNED(1'b0)) dut_na (
      .clk(clk), .reset(reset), .store_valid(store_valid[1]), .store_ready(ready[1]),
      .store_address(store_address), .store_data(store_data), .funct3(funct3),
      .mem_req(req[1]), .mem_addr(addr_o[1]), .mem_wdata(wdata_o[1]), .mem_wstrb(wstrb_o[1]),
      .mem_ack(mem_ack[1]), .store_done(done[1]), .store_error(err[1]));

   memory_storer #(.TIMEOUT_CYCLES(4)) dut_to (
      .clk(clk), .reset(reset), .store_valid(store_valid[2]), .store_ready(ready[2]),
      .store_address(store_address), .store_data(store_data), .funct3(funct3),
      .mem_req(req[2]), .mem_addr(addr_o[2]), .mem_wdata(wdata_o[2]), .mem_wstrb(wstrb_o[2]),
      .mem_ack(mem_ack[2]), .store_done(done[2]), .store_error(err[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int idx, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f);
      store_address = a;
      store_data    = d;
      funct3        = f;
      store_valid   = 3'b000;
      store_valid[idx] = 1'b1;
   endtask

   task automatic chk_wr(input string tag, input int idx, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
      chk({tag, "_req"},   {31'b0, req[idx]}, 32'h1);
      chk({tag, "_addr"},  addr_o[idx], a);
      chk({tag, "_wdata"}, wdata_o[idx], d);
      chk({tag, "_wstrb"}, {28'b0, wstrb_o[idx]}, {28'b0, s});
   endtask

   initial begin
      // Reset state
      #3;
      chk("rst_req",   {31'b0, req[0]}, 32'h0);
      chk("rst_addr",  addr_o[0], 32'h0);
      chk("rst_wdata", wdata_o[0], 32'h0);
      chk("rst_wstrb", {28'b0, wstrb_o[0]}, 32'h0);
      chk("rst_done",  {31'b0, done[0]}, 32'h0);
      chk("rst_err",   {31'b0, err[0]}, 32'h0);
      chk("rst_ready", {29'b0, ready}, 32'h7);
      step();
      reset = 1'b0;
      step();

      // Reset while WR0 waits for an ack
      issue(0, 32'h0000_0100, 32'hCAFE_F00D, 3'b010);
      step();
      store_valid = 3'b000;
      chk_wr("mid_wr0", 0, 32'h100, 32'hCAFE_F00D, 4'b1111);
      step();
      #2 reset = 1'b1;
      #1;
      chk("arst_req",   {31'b0, req[0]}, 32'h0);
      chk("arst_ready", {31'b0, ready[0]}, 32'h1);
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("arst_no_pulse", {30'b0, done[0], err[0]}, 32'h0);
         step();
      end

      // Aligned sw, ack held high: done two cycles after accept
      mem_ack[0] = 1'b1;
      issue(0, 32'h0000_1000, 32'h1122_3344, 3'b010);
      chk("sw_ready", {31'b0, ready[0]}, 32'h1);
      step();
      store_valid = 3'b000;
      chk_wr("sw", 0, 32'h1000, 32'h1122_3344, 4'b1111);
      chk("sw_done_c1", {31'b0, done[0]}, 32'h0);
      step();
      chk("sw_done_c2", {31'b0, done[0]}, 32'h1);
      chk("sw_req_c2",  {31'b0, req[0]}, 32'h0);
      step();
      chk("sw_done_c3", {31'b0, done[0]}, 32'h0);

      // sb at offset 3, then back-to-back misaligned sh
      issue(0, 32'h0000_1003, 32'hFFFF_FFAB, 3'b000);
      step();
      store_valid = 3'b000;
      chk_wr("sb", 0, 32'h1000, 32'hAB00_0000, 4'b1000);
      step();
      chk("sb_done",  {31'b0, done[0]}, 32'h1);
      chk("sb_req",   {31'b0, req[0]}, 32'h0);
      chk("sb_ready", {31'b0, ready[0]}, 32'h1);
      issue(0, 32'h0000_1003, 32'h0000_BEEF, 3'b001);
      step();
      store_valid = 3'b000;
      chk_wr("sh_w0", 0, 32'h1000, 32'hEF00_0000, 4'b1000);
      step();
      chk_wr("sh_w1", 0, 32'h1004, 32'h0000_00BE, 4'b0001);
      chk("sh_done_early", {31'b0, done[0]}, 32'h0);
      step();
      chk("sh_done", {31'b0, done[0]}, 32'h1);
      mem_ack[0] = 1'b0;
      step();

      // Word-crossing sw at the top of memory, ack delayed three cycles per write
      issue(0, 32'hFFFF_FFFE, 32'h1122_3344, 3'b010);
      step();
      store_valid = 3'b000;
      for (int i = 0; i < 3; i++) begin
         chk_wr("wrap_w0_wait", 0, 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100);
         step();
      end
      chk_wr("wrap_w0_ack", 0, 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100);
      mem_ack[0] = 1'b1;
      step();
      mem_ack[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk_wr("wrap_w1_wait", 0, 32'h0000_0000, 32'h0000_1122, 4'b0011);
         chk("wrap_no_done", {31'b0, done[0]}, 32'h0);
         step();
      end
      chk_wr("wrap_w1_ack", 0, 32'h0000_0000, 32'h0000_1122, 4'b0011);
      mem_ack[0] = 1'b1;
      step();
      mem_ack[0] = 1'b0;
      chk("wrap_done", {31'b0, done[0]}, 32'h1);
      chk("wrap_req",  {31'b0, req[0]}, 32'h0);

      // Stray ack while idle is ignored
      mem_ack[0] = 1'b1;
      step();
      chk("idle_ack_done", {30'b0, done[0], req[0]}, 32'h0);
      step();
      chk("idle_ack_done2", {30'b0, done[0], req[0]}, 32'h0);
      mem_ack[0] = 1'b0;

      // Illegal funct3
      issue(0, 32'h0000_1000, 32'h5555_5555, 3'b011);
      step();
      store_valid = 3'b000;
      chk("ill_err",   {31'b0, err[0]}, 32'h1);
      chk("ill_req",   {31'b0, req[0]}, 32'h0);
      chk("ill_ready", {31'b0, ready[0]}, 32'h0);
      step();
      chk("ill_err_c2", {31'b0, err[0]}, 32'h0);
      chk("ill_ready2", {31'b0, ready[0]}, 32'h1);

      // Misalignment disabled: crossing sh errors, in-word sh writes
      issue(1, 32'h0000_0003, 32'h0000_BEEF, 3'b001);
      step();
      store_valid = 3'b000;
      chk("na_err", {31'b0, err[1]}, 32'h1);
      chk("na_req", {31'b0, req[1]}, 32'h0);
      step();
      chk("na_err_c2", {31'b0, err[1]}, 32'h0);
      mem_ack[1] = 1'b1;
      issue(1, 32'h0000_0002, 32'h1234_CAFE, 3'b001);
      step();
      store_valid = 3'b000;
      chk_wr("na_sh2", 1, 32'h0000_0000, 32'hCAFE_0000, 4'b1100);
      step();
      chk("na_sh2_done", {31'b0, done[1]}, 32'h1);
      chk("na_sh2_err",  {31'b0, err[1]}, 32'h0);
      mem_ack[1] = 1'b0;

      // Timeout: four cycles of unanswered mem_req, then error
      issue(2, 32'h0000_0200, 32'hDEAD_BEEF, 3'b010);
      step();
      store_valid = 3'b000;
      for (int i = 0; i < 4; i++) begin
         chk("to_req_wait", {30'b0, req[2], err[2]}, 32'h2);
         step();
      end
      chk("to_err", {31'b0, err[2]}, 32'h1);
      chk("to_req", {31'b0, req[2]}, 32'h0);
      step();
      chk("to_err_c2", {31'b0, err[2]}, 32'h0);
      chk("to_ready",  {31'b0, ready[2]}, 32'h1);

      // Ack on the last cycle before the timeout wins
      issue(2, 32'h0000_0204, 32'h0BAD_F00D, 3'b010);
      step();
      store_valid = 3'b000;
      step();
      step();
      step();
      chk_wr("to_race", 2, 32'h0000_0204, 32'h0BAD_F00D, 4'b1111);
      mem_ack[2] = 1'b1;
      step();
      mem_ack[2] = 1'b0;
      chk("to_race_done", {31'b0, done[2]}, 32'h1);
      chk("to_race_err",  {31'b0, err[2]}, 32'h0);
      step();
      chk("to_race_err2", {31'b0, err[2]}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
